// File: rtl/crt_clock_divider_pkg.sv
// Shared constants for the CRT clock/strobe generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package crt_clock_divider_pkg;

   // Channel operating modes
   localparam logic MODE_INT = 1'b0;   // exact 50% integer divide
   localparam logic MODE_NCO = 1'b1;   // fractional phase accumulator

   // 25 MHz pixel clock from a 100 MHz Clock: toggle every 2 cycles
   localparam int VGA_HALF_100MHZ = 2;

   // Half-period every channel starts with out of reset
   localparam int DEFAULT_RESET_HALF = VGA_HALF_100MHZ;

endpackage

// File: rtl/crt_clock_channel.sv
// One divider channel: integer counter or NCO accumulator with shadowed config.
// Latency: outputs registered; a new config becomes active at the next period boundary.
// Backpressure: Pending stays high from accepted write until the config is applied.
//
// Ports: Clock/Reset; Enable run enable; CfgWrite accepted config strobe with
// CfgMode/CfgValue; Pending config waiting; PixelClock, Tick, Locked outputs.
module crt_clock_channel
   import crt_clock_divider_pkg::*;
#(
   parameter int CNT_W      = 10,
   parameter int RESET_HALF = DEFAULT_RESET_HALF
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             CfgWrite,
   input  logic             CfgMode,
   input  logic [CNT_W-1:0] CfgValue,
   output logic             Pending,
   output logic             PixelClock,
   output logic             Tick,
   output logic             Locked
);

   logic             activeMode;
   logic [CNT_W-1:0] activeValue;
   logic             shadowMode;
   logic [CNT_W-1:0] shadowValue;
   logic [CNT_W-1:0] count;      // integer counter or NCO accumulator

   logic             halted;
   logic             boundary;   // cycle in which PixelClock falls 1->0
   logic             applyCfg;
   logic             pixelNext;
   logic [CNT_W-1:0] countNext;
   logic [CNT_W-1:0] accNext;

   always_comb begin
      halted    = !Enable || (activeValue == '0);
      accNext   = count + activeValue;     // wraps modulo 2^CNT_W
      boundary  = 1'b0;
      pixelNext = PixelClock;
      countNext = count;
      if (halted) begin
         pixelNext = 1'b0;
         countNext = '0;
      end else if (activeMode == MODE_NCO) begin
         countNext = accNext;
         pixelNext = accNext[CNT_W-1];
         boundary  = PixelClock && !accNext[CNT_W-1];
      end else if (count == activeValue - CNT_W'(1)) begin
         countNext = '0;
         pixelNext = !PixelClock;
         boundary  = PixelClock;
      end else begin
         countNext = count + CNT_W'(1);
      end
      // A pending config only swaps in where the output is already low
      // (boundary or halt), so the new setting starts from a clean low phase.
      applyCfg = Pending && (halted || boundary);
      if (applyCfg) begin
         countNext = '0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         activeMode  <= MODE_INT;
         activeValue <= CNT_W'(RESET_HALF);
         shadowMode  <= MODE_INT;
         shadowValue <= CNT_W'(RESET_HALF);
         Pending     <= 1'b0;
         count       <= '0;
         PixelClock  <= 1'b0;
         Tick        <= 1'b0;
         Locked      <= 1'b0;
      end else begin
         count      <= countNext;
         PixelClock <= pixelNext;
         Tick       <= pixelNext && !PixelClock;

         // CfgWrite only arrives while not pending, so it never races applyCfg;
         // a write landing on a boundary waits for the following boundary.
         if (CfgWrite) begin
            shadowMode  <= CfgMode;
            shadowValue <= CfgValue;
            Pending     <= 1'b1;
         end else if (applyCfg) begin
            activeMode  <= shadowMode;
            activeValue <= shadowValue;
            Pending     <= 1'b0;
         end

         if (halted || CfgWrite) begin
            Locked <= 1'b0;
         end else if (boundary && !Pending) begin
            Locked <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/crt_clock_divider.sv
// Multi-channel programmable pixel clock / strobe generator.
// Latency: outputs registered; CfgError one cycle after an out-of-range accept.
// Backpressure: CfgReady low while the selected channel holds a pending config.
//
// Ports: Clock/Reset; Enable per-channel run; CfgValid/CfgReady/CfgChannel/
// CfgMode/CfgValue config port; CfgError; PixelClock, Tick, Locked per channel.
module crt_clock_divider
   import crt_clock_divider_pkg::*;
#(
   parameter int CNT_W      = 10,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = 3,
   parameter int RESET_HALF = DEFAULT_RESET_HALF
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] Enable,
   input  logic              CfgValid,
   output logic              CfgReady,
   input  logic [CH_W-1:0]   CfgChannel,
   input  logic              CfgMode,
   input  logic [CNT_W-1:0]  CfgValue,
   output logic              CfgError,
   output logic [NUM_CH-1:0] PixelClock,
   output logic [NUM_CH-1:0] Tick,
   output logic [NUM_CH-1:0] Locked
);

   logic [NUM_CH-1:0] pending;
   logic              channelValid;

   // Decode by comparison rather than indexing, so out-of-range channel
   // numbers fall through to "accepted, no effect".
   always_comb begin
      channelValid = 1'b0;
      CfgReady     = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (CfgChannel == CH_W'(i)) begin
            channelValid = 1'b1;
            CfgReady     = !pending[i];
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         CfgError <= 1'b0;
      end else begin
         CfgError <= CfgValid && !channelValid;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : gChannel
      logic cfgWrite;
      assign cfgWrite = CfgValid && CfgReady && (CfgChannel == CH_W'(g));

      crt_clock_channel #(
         .CNT_W      (CNT_W),
         .RESET_HALF (RESET_HALF)
      ) uChannel (
         .Clock      (Clock),
         .Reset      (Reset),
         .Enable     (Enable[g]),
         .CfgWrite   (cfgWrite),
         .CfgMode    (CfgMode),
         .CfgValue   (CfgValue),
         .Pending    (pending[g]),
         .PixelClock (PixelClock[g]),
         .Tick       (Tick[g]),
         .Locked     (Locked[g])
      );
   end

endmodule

// File: tb/tb_crt_clock_divider.sv
// Directed self-checking bench for crt_clock_divider (CNT_W=10, NUM_CH=2, CH_W=3).
// Latency: n/a. Backpressure: n/a.
// Inputs are driven and outputs sampled 1 ns after each rising Clock edge.
module tb_crt_clock_divider;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] Enable = 2'b01;
   logic       CfgValid = 1'b0;
   logic       CfgReady;
   logic [2:0] CfgChannel = 3'd0;
   logic       CfgMode = 1'b0;
   logic [9:0] CfgValue = 10'd0;
   logic       CfgError;
   logic [1:0] PixelClock;
   logic [1:0] Tick;
   logic [1:0] Locked;

   int checkCount = 0;
   int errorCount = 0;
   int tickTotal;

   crt_clock_divider #(
      .CNT_W      (10),
      .NUM_CH     (2),
      .CH_W       (3),
      .RESET_HALF (2)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Enable     (Enable),
      .CfgValid   (CfgValid),
      .CfgReady   (CfgReady),
      .CfgChannel (CfgChannel),
      .CfgMode    (CfgMode),
      .CfgValue   (CfgValue),
      .CfgError   (CfgError),
      .PixelClock (PixelClock),
      .Tick       (Tick),
      .Locked     (Locked)
   );

   always #5 Clock = ~Clock;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge Clock);
      #1;
   endtask

   // Run n cycles on one channel; sequence bits read left to right = cycle 1..n.
   task automatic runSeq(input string tag, input int ch, input int n,
                         input logic [15:0] pixSeq, input logic [15:0] tickSeq,
                         input logic [15:0] lockSeq);
      for (int i = 0; i < n; i++) begin
         stepClock();
         checkValue($sformatf("%s[%0d] pix/tick/lock", tag, i),
                    {29'b0, PixelClock[ch], Tick[ch], Locked[ch]},
                    {29'b0, pixSeq[n-1-i], tickSeq[n-1-i], lockSeq[n-1-i]});
      end
   endtask

   task automatic waitTick(input int ch);
      int n = 0;
      while (Tick[ch] !== 1'b1 && n < 20) begin
         stepClock();
         n++;
      end
      checkValue("wait_tick", {31'b0, Tick[ch]}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset defaults ----
      #2;
      checkValue("reset_pix",  {30'b0, PixelClock}, 32'd0);
      checkValue("reset_tick", {30'b0, Tick},       32'd0);
      checkValue("reset_lock", {30'b0, Locked},     32'd0);
      checkValue("reset_err",  {31'b0, CfgError},   32'd0);
      checkValue("reset_rdy",  {31'b0, CfgReady},   32'd1);
      stepClock();
      stepClock();
      Reset = 1'b0;

      // ch0 N=2: period 4, Locked after first fall; ch1 disabled
      runSeq("rst_ch0", 0, 8, 16'b01100110, 16'b01000100, 16'b00011111);
      checkValue("ch1_held", {30'b0, PixelClock[1], Locked[1]}, 32'd0);
      runSeq("pre_cfg", 0, 2, 16'b01, 16'b01, 16'b11);

      // ---- integer reconfiguration to N=3 during a high phase ----
      CfgValid = 1'b1; CfgChannel = 3'd0; CfgMode = 1'b0; CfgValue = 10'd3;
      checkValue("cfg_rdy_before", {31'b0, CfgReady}, 32'd1);
      runSeq("cfg_accept", 0, 1, 16'b1, 16'b0, 16'b0);
      CfgValid = 1'b0;
      checkValue("cfg_rdy_pending", {31'b0, CfgReady}, 32'd0);
      runSeq("int3", 0, 7, 16'b0001110, 16'b0001000, 16'b0000001);
      checkValue("cfg_rdy_after", {31'b0, CfgReady}, 32'd1);
      runSeq("int3b", 0, 6, 16'b001110, 16'b001000, 16'b111111);

      // ---- NCO mode on ch1, configured while halted ----
      CfgValid = 1'b1; CfgChannel = 3'd1; CfgMode = 1'b1; CfgValue = 10'd256;
      checkValue("nco_rdy", {31'b0, CfgReady}, 32'd1);
      stepClock();
      CfgValid = 1'b0;
      checkValue("nco_rdy_pending", {31'b0, CfgReady}, 32'd0);
      stepClock();
      checkValue("nco_rdy_applied", {31'b0, CfgReady}, 32'd1);
      Enable = 2'b11;
      runSeq("nco256", 1, 8, 16'b01100110, 16'b01000100, 16'b00011111);

      // value 384: applied at the next wrap, then 3 ticks per 8 cycles
      CfgValid = 1'b1; CfgChannel = 3'd1; CfgMode = 1'b1; CfgValue = 10'd384;
      runSeq("nco384_acc", 1, 1, 16'b0, 16'b0, 16'b0);
      CfgValid = 1'b0;
      runSeq("nco384", 1, 11, 16'b11001011010, 16'b10001010010, 16'b00000111111);
      tickTotal = 0;
      for (int i = 0; i < 8; i++) begin
         stepClock();
         tickTotal += int'(Tick[1]);
      end
      checkValue("nco384_ticks_per_8", tickTotal, 32'd3);

      // ---- halt / resume ch0 (N=3) ----
      waitTick(0);
      Enable = 2'b10;
      runSeq("halt", 0, 2, 16'b00, 16'b00, 16'b00);
      Enable = 2'b11;
      runSeq("resume", 0, 3, 16'b001, 16'b001, 16'b000);

      // ---- invalid channel ----
      CfgValid = 1'b1; CfgChannel = 3'd5; CfgMode = 1'b0; CfgValue = 10'd7;
      checkValue("inv_rdy", {31'b0, CfgReady}, 32'd1);
      stepClock();
      CfgValid = 1'b0;
      checkValue("inv_err_pulse", {31'b0, CfgError}, 32'd1);
      checkValue("inv_ch1_locked", {31'b0, Locked[1]}, 32'd1);
      stepClock();
      checkValue("inv_err_clear", {31'b0, CfgError}, 32'd0);
      CfgChannel = 3'd0;
      #1 checkValue("inv_rdy_ch0", {31'b0, CfgReady}, 32'd1);
      CfgChannel = 3'd1;
      #1 checkValue("inv_rdy_ch1", {31'b0, CfgReady}, 32'd1);

      // ---- asynchronous reset mid-period with a pending config ----
      waitTick(0);
      CfgValid = 1'b1; CfgChannel = 3'd0; CfgMode = 1'b0; CfgValue = 10'd5;
      stepClock();
      CfgValid = 1'b0;
      checkValue("ar_pending", {31'b0, CfgReady}, 32'd0);
      checkValue("ar_pix_high", {31'b0, PixelClock[0]}, 32'd1);
      #3;
      Reset = 1'b1;
      #1;
      checkValue("ar_pix",  {30'b0, PixelClock}, 32'd0);
      checkValue("ar_tick", {30'b0, Tick},       32'd0);
      checkValue("ar_lock", {30'b0, Locked},     32'd0);
      checkValue("ar_rdy",  {31'b0, CfgReady},   32'd1);
      stepClock();
      Reset = 1'b0;
      Enable = 2'b01;
      // back to the reset half-period, not the discarded N=5
      runSeq("ar_resume", 0, 4, 16'b0110, 16'b0100, 16'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
